// File: rtl/dmem_access_unit_pkg.sv
// Shared constants for the memory-stage load/store unit:
// access codes carried on lshbM, data_size bus encodings and FSM state codes.
package dmem_access_unit_pkg;

    // Access width/sign codes driven by the core on lshbM
    localparam logic [2:0] LS_W  = 3'b000;
    localparam logic [2:0] LS_HS = 3'b001;
    localparam logic [2:0] LS_HU = 3'b010;
    localparam logic [2:0] LS_BS = 3'b011;
    localparam logic [2:0] LS_BU = 3'b100;

    // data_size encodings on the SRAM bus
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Handshake FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bus size for an access code; unknown codes behave as word accesses
    function automatic logic [1:0] ls_size(input logic [2:0] code);
        case (code)
            LS_HS, LS_HU: ls_size = SIZE_HALF;
            LS_BS, LS_BU: ls_size = SIZE_BYTE;
            default:      ls_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_ls_format.sv
// ls_format: purely combinational data formatting for the load/store unit.
// Replicates store data across byte lanes, builds the byte strobes and
// extracts/extends the selected lane of a load. addr_lo is expected to be
// already aligned to the access size.
module ls_format
    import dmem_access_unit_pkg::*;
(
    input  logic [2:0]  lshb,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    // Store replication and strobe generation; loads never assert strobes
    always_comb begin
        wdata = wd;
        wstrb = 4'b0000;
        case (ls_size(lshb))
            SIZE_BYTE: begin
                wdata = {4{wd[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata = {2{wd[15:0]}};
                wstrb = 4'b0011 << addr_lo;
            end
            default: begin
                wdata = wd;
                wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            wstrb = 4'b0000;
        end
    end

    // Load lane select by low address bits, then sign/zero extension
    always_comb begin
        lane    = rdata >> {addr_lo, 3'b000};
        ld_data = rdata;
        case (lshb)
            LS_HS:   ld_data = {{16{lane[15]}}, lane[15:0]};
            LS_HU:   ld_data = {16'h0000, lane[15:0]};
            LS_BS:   ld_data = {{24{lane[7]}}, lane[7:0]};
            LS_BU:   ld_data = {24'h000000, lane[7:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage load/store unit between the core and the
// data SRAM bus. Issues a request, waits for addr_ok/data_ok from a
// variable-latency slave while stalling the pipeline, and returns the
// extended load result in the DONE cycle.
// Optional feature macro DMEM_MISALIGN_EXC_EN: misaligned half/word
// accesses raise adelM/adesM and are not issued. Without it the flags are
// tied low and the address low bits are forced aligned.
// Bus handshake: data_req is held until the cycle data_addr_ok is seen; the
// request is accepted in that cycle. data_data_ok completes the transfer
// (it may coincide with data_addr_ok); data_data_ok without an accepted
// request is ignored.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [2:0]        lshbM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [1:0]        dbg_state
);

    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  lshb_n;
    logic [1:0]  size_n;
    logic [31:0] addr_eff;
    logic        access;
    logic        issue;
    logic        req;
    logic        stall;

    // Unknown access codes fall back to word
    assign lshb_n = (lshbM > LS_BU) ? LS_W : lshbM;
    assign size_n = ls_size(lshb_n);
    assign access = memreadM | memwriteM;

`ifdef DMEM_MISALIGN_EXC_EN
    logic misalign;

    assign misalign = ((size_n == SIZE_HALF) && aluoutM[0]) ||
                      ((size_n == SIZE_WORD) && (aluoutM[1:0] != 2'b00));
    assign addr_eff = aluoutM;
    assign adelM    = rst & memreadM & misalign;
    assign adesM    = rst & memwriteM & misalign;
    assign issue    = access & ~misalign;
`else
    // Force the address aligned to the access size
    always_comb begin
        addr_eff = aluoutM;
        if (size_n == SIZE_HALF) begin
            addr_eff[0] = 1'b0;
        end else if (size_n == SIZE_WORD) begin
            addr_eff[1:0] = 2'b00;
        end
    end

    assign adelM = 1'b0;
    assign adesM = 1'b0;
    assign issue = access;
`endif

    ls_format u_ls_format (
        .lshb     (lshb_n),
        .is_store (memwriteM),
        .addr_lo  (addr_eff[1:0]),
        .wd       (writedataM),
        .rdata    (rdata_q),
        .wdata    (data_wdata),
        .wstrb    (data_wstrb),
        .ld_data  (readdataM)
    );

    assign data_addr = ADDR_W'(addr_eff);
    assign data_wr   = memwriteM;
    assign data_size = size_n;
    assign dbg_state = state_q;

    // Handshake FSM next-state, request/stall and read-data capture
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state_d = ST_DONE;
                            rdata_d = data_rdata;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_DONE;
                    rdata_d = data_rdata;
                end
            end
            ST_DONE: begin
                // Pipeline advances at the end of this cycle; never reissue
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // While reset is held nothing is requested and the pipeline is free
    assign data_req = req & rst;
    assign stallM   = stall & rst;

    // State and captured read-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed accesses from the
// test plan, a reset-in-WAIT case, the misalignment case for the current
// build and a short random run against a small reference model.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM;
    logic [2:0]  lshbM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Values observed by the last run_access call
    logic [31:0] obs_addr, obs_wdata, obs_rd;
    logic [3:0]  obs_strb;
    logic [1:0]  obs_size;
    int          obs_stall, obs_total, obs_waits;

    // Clock
    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .memreadM     (memreadM),
        .memwriteM    (memwriteM),
        .lshbM        (lshbM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_half(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd2);
    endfunction

    function automatic bit m_is_byte(input logic [2:0] code);
        return (code == 3'd3) || (code == 3'd4);
    endfunction

    function automatic logic [31:0] m_align(input logic [2:0] code, input logic [31:0] a);
        logic [31:0] r;
        r = a;
        if (m_is_half(code)) r[0] = 1'b0;
        else if (!m_is_byte(code)) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [31:0] m_eff(input logic [2:0] code, input logic [31:0] a);
`ifdef DMEM_MISALIGN_EXC_EN
        return a;
`else
        return m_align(code, a);
`endif
    endfunction

    function automatic logic [1:0] m_size(input logic [2:0] code);
        if (m_is_byte(code)) return 2'd0;
        if (m_is_half(code)) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [3:0] m_strb(input logic wr, input logic [2:0] code, input logic [31:0] a);
        int k;
        k = int'(a[1:0]);
        if (!wr) return 4'b0000;
        if (m_is_byte(code)) return 4'(1 << k);
        if (m_is_half(code)) return 4'(3 << k);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] code, input logic [31:0] wd);
        if (m_is_byte(code)) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (m_is_half(code)) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] code, input logic [31:0] a, input logic [31:0] rd);
        logic [7:0] b [4];
        int k;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        k = int'(a[1:0]);
        case (code)
            3'd1:    return {{16{b[k+1][7]}}, b[k+1], b[k]};
            3'd2:    return {16'h0, b[k+1], b[k]};
            3'd3:    return {{24{b[k][7]}}, b[k]};
            3'd4:    return {24'h0, b[k]};
            default: return rd;
        endcase
    endfunction

    // ---------------- driver + slave ----------------
    // Called at posedge+1. a_lat: cycles before addr_ok; d_lat: cycles from
    // address acceptance to data_ok (0 = same cycle); stray: data_ok driven
    // while addr_ok is still low (must be ignored).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] code,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int a_lat, input int d_lat,
                              input logic stray);
        int cyc, since, exp_stall;
        bit acc, done, seen;
        logic [31:0] ea;
        ea = m_eff(code, addr);
        memreadM   = rd;
        memwriteM  = wr;
        lshbM      = code;
        aluoutM    = addr;
        writedataM = wd;
        if (rd) exp_q.push_back(m_load(code, ea, rdat));
        exp_stall = a_lat + 1 + d_lat;
        cyc = 0; since = 0; acc = 0; done = 0; seen = 0;
        obs_stall = 0; obs_waits = 0;
        while (!done && cyc < 64) begin
            if (!acc) begin
                data_addr_ok = (cyc >= a_lat);
                data_data_ok = (cyc >= a_lat) ? (d_lat == 0) : stray;
            end else begin
                since++;
                data_addr_ok = 1'b0;
                data_data_ok = (since >= d_lat);
            end
            data_rdata = data_data_ok ? rdat : 32'hDEAD_BEEF;
            @(negedge clk);
            if (dbg_state == ST_DONE) begin
                done = 1;
                check("done_stall", stallM, 0);
                check("done_req", data_req, 0);
                if (rd) check("readdata", readdataM, exp_q.pop_front());
                obs_rd = readdataM;
            end else begin
                if (stallM) obs_stall++;
                if (dbg_state == ST_WAIT) obs_waits++;
                if (data_req && !seen) begin
                    seen      = 1;
                    obs_addr  = data_addr;
                    obs_wdata = data_wdata;
                    obs_strb  = data_wstrb;
                    obs_size  = data_size;
                    check("req_addr", data_addr, ea);
                    check("req_wr", data_wr, wr);
                    check("req_size", data_size, m_size(code));
                    check("req_strb", data_wstrb, m_strb(wr, code, ea));
                    if (wr) check("req_wdata", data_wdata, m_wdata(code, wd));
                end
                if (data_req && data_addr_ok) acc = 1;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        obs_total = cyc;
        check("completed", done, 1);
        check("stall_cycles", obs_stall, exp_stall);
        memreadM     = 1'b0;
        memwriteM    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; lshbM = LS_W;
        aluoutM = '0; writedataM = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", data_req, 0);
        check("rst_stall", stallM, 0);
        check("rst_readdata", readdataM, 0);
        check("rst_adel", adelM, 0);
        check("rst_ades", adesM, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store, zero-wait slave
        run_access(0, 1, LS_W, 32'h10, 32'h1122_3344, 32'h0, 0, 1, 0);
        check("sw_strb", obs_strb, 4'b1111);
        check("sw_wdata", obs_wdata, 32'h1122_3344);
        check("sw_stall", obs_stall, 2);
        check("sw_total", obs_total, 3);

        // Byte store at 0x13
        run_access(0, 1, LS_BU, 32'h13, 32'h0000_00AB, 32'h0, 0, 1, 0);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        check("sb_strb", obs_strb, 4'b1000);
        check("sb_size", obs_size, 2'd0);

        // Byte loads at 0x12
        run_access(1, 0, LS_BS, 32'h12, 32'h0, 32'h00F5_0000, 0, 1, 0);
        check("lb_value", obs_rd, 32'hFFFF_FFF5);
        run_access(1, 0, LS_BU, 32'h12, 32'h0, 32'h00F5_0000, 0, 1, 0);
        check("lbu_value", obs_rd, 32'h0000_00F5);

        // Half unsigned load, data_ok three cycles late
        run_access(1, 0, LS_HU, 32'h2, 32'h0, 32'h8001_1234, 0, 4, 0);
        check("lhu_value", obs_rd, 32'h0000_8001);
        check("lhu_stall", obs_stall, 5);

        // Same-cycle addr_ok and data_ok
        run_access(1, 0, LS_W, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        check("same_total", obs_total, 2);
        check("same_waits", obs_waits, 0);
        check("same_value", obs_rd, 32'hCAFE_F00D);

        // Stray data_ok while addr_ok is low must be ignored
        run_access(1, 0, LS_HS, 32'h6, 32'h0, 32'h8000_0001, 2, 1, 1);
        check("stray_value", obs_rd, 32'hFFFF_8000);

        // Back in IDLE with no access
        @(negedge clk);
        check("idle_state", dbg_state, ST_IDLE);
        check("idle_stall", stallM, 0);
        @(posedge clk); #1;

        // Reset asserted while in WAIT
        memreadM = 1'b1; lshbM = LS_W; aluoutM = 32'h40;
        data_addr_ok = 1'b1; data_data_ok = 1'b0;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        check("pre_rst_state", dbg_state, ST_WAIT);
        rst = 1'b0;
        #1;
        check("wrst_req", data_req, 0);
        check("wrst_stall", stallM, 0);
        check("wrst_state", dbg_state, ST_IDLE);
        check("wrst_readdata", readdataM, 0);
        memreadM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Misaligned word load at 0x6
`ifdef DMEM_MISALIGN_EXC_EN
        memreadM = 1'b1; lshbM = LS_W; aluoutM = 32'h6;
        @(negedge clk);
        check("mis_adel", adelM, 1);
        check("mis_ades", adesM, 0);
        check("mis_req", data_req, 0);
        check("mis_stall", stallM, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_state", dbg_state, ST_IDLE);
        memreadM = 1'b0;
        @(posedge clk); #1;
`else
        run_access(1, 0, LS_W, 32'h6, 32'h0, 32'h1357_9BDF, 0, 1, 0);
        check("mis_addr", obs_addr, 32'h4);
        check("mis_value", obs_rd, 32'h1357_9BDF);
        check("mis_adel", adelM, 0);
`endif

        // Random accesses
        for (int n = 0; n < 12; n++) begin
            logic        r_rd;
            logic [2:0]  r_code;
            logic [31:0] r_addr;
            r_rd   = 1'($urandom_range(0, 1));
            r_code = 3'($urandom_range(0, 7));
            r_addr = $urandom;
`ifdef DMEM_MISALIGN_EXC_EN
            r_addr = m_align(r_code, r_addr);
`endif
            run_access(r_rd, !r_rd, r_code, r_addr, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage load/store unit between the pipelined MIPS core and the data SRAM bus. It consumes the core's M-stage access (address, store data, write enable, width/sign code) and formats stores into byte strobes. It runs a request/address-ok/data-ok handshake with variable-latency memory, stalling the pipeline until completion. It returns the load result as an aligned, extended `readdataM`.

## Interface
Parameters:
- `ADDR_W`, 32, data bus address width.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `memreadM` in 1: M-stage load.
- `memwriteM` in 1: M-stage store. Never high together with `memreadM`.
- `lshbM` in 3: access code. 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Others are treated as word.
- `aluoutM` in 32: effective address.
- `writedataM` in 32: store data, right-justified.
- `readdataM` out 32: extended load result. Valid in the DONE cycle.
- `stallM` out 1: hold F/D/E/M stages.
- `adelM`, `adesM` out 1: misaligned load/store flags. Present only with the macro.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2 (0 byte, 1 half, 2 word), `data_addr` out `ADDR_W`, `data_wdata` out 32, `data_wstrb` out 4.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, no access: `data_req`=0, `stallM`=0.
- IDLE, access (`memreadM|memwriteM`, aligned):
  - `data_req`=1 combinationally; `stallM`=1.
  - `addr_ok`=0: stay in IDLE, request held.
  - `addr_ok`=1, `data_ok`=0: go to WAIT.
  - `addr_ok`=1 and `data_ok`=1 in the same cycle: go to DONE, capture `data_rdata`.
- WAIT: `data_req`=0, `stallM`=1. `data_ok`=1 captures `data_rdata` into `rdata_q` and goes to DONE.
- DONE: `stallM`=0; the pipeline advances at the end of this cycle; go to IDLE. The same instruction is never reissued.
- Store formatting:
  - byte: `wdata`={4{wd[7:0]}}, `wstrb`=0001<<addr[1:0].
  - half: `wdata`={2{wd[15:0]}}, `wstrb`=0011<<addr[1:0].
  - word: `wstrb`=1111.
  - Loads drive `wstrb`=0000.
- Load extraction from `rdata_q`: select the lane by addr[1:0], then sign- or zero-extend per `lshbM`.
- `data_addr` = `aluoutM`. `data_addr`, `data_wr`, `data_size`, `data_wdata` and `data_wstrb` are driven from the M-stage inputs, which are stable while stalled.

## Timing
- Reset values: `data_req`=0, `stallM`=0, `readdataM`=0 (`rdata_q`=0), flags=0, state IDLE.
- Zero-wait slave (`addr_ok` in the issue cycle, `data_ok` next cycle): instruction occupies M for 3 cycles (IDLE-req, WAIT, DONE). Each extra slave wait cycle adds one cycle.
- Same-cycle `addr_ok` and `data_ok`: 2 cycles.
- `data_ok` seen in IDLE without `addr_ok`: ignored.
- Reset mid-transaction: FSM returns to IDLE at once and `data_req` drops. The bus slave shares `rst`, so no stale `data_ok` arrives.
- `readdataM` is only meaningful in DONE; in other cycles it holds its last value.

## Configuration
- `DMEM_MISALIGN_EXC_EN` defined:
  - Half access with addr[0]≠0, or word access with addr[1:0]≠0, raises `adelM`/`adesM` combinationally.
  - No request is issued; `stallM`=0; the FSM stays in IDLE.
- Undefined:
  - Flags tied to 0.
  - Address low bits are forced aligned (half clears bit 0, word clears bits 1:0) before issue, strobe generation and extraction.

## Structure
- Shared package/header: `lshb` code constants (LS_W, LS_HS, LS_HU, LS_BS, LS_BU), the `data_size` encodings, and the FSM state constants.
- One sub-module, `ls_format`: purely combinational store replication, strobe generation and load extraction/extension. It is instantiated once; the FSM and `rdata_q` stay in the parent.

## Test plan
- Word store `aluoutM`=0x10, `wd`=0x11223344, zero-wait slave → `wstrb`=1111, `wdata`=0x11223344, `stallM` high 2 cycles then low 1 cycle.
- Byte store at 0x13, `wd`=0xAB → `wdata`=0xABABABAB, `wstrb`=1000, `data_size`=0.
- Load byte signed at 0x12, `rdata`=0x00F50000 → `readdataM`=0xFFFFFFF5. Load byte unsigned at the same address → 0x000000F5.
- Half-unsigned load at 0x2, `rdata`=0x8001xxxx, slave `data_ok` 3 cycles late → `readdataM`=0x00008001 in DONE, `stallM` high for 5 cycles.
- Same-cycle `addr_ok` and `data_ok` → state goes IDLE→DONE, 2-cycle residency. Reset asserted in WAIT → `data_req`=0, `stallM`=0, state IDLE immediately.
- With `DMEM_MISALIGN_EXC_EN`, word load at 0x6 → `adelM`=1, `data_req`=0, `stallM`=0. Without it → request issued to 0x4.
